// File: rtl/f1_start_ctrl_if.sv
// Start-light controller signal bundle: trigger/button inputs, light bar,
// phase strobes and reaction-time result.
interface f1_start_ctrl_if #(
  parameter int REACT_W = 16
);
  logic               trigger;
  logic               react;
  logic [7:0]         data_out;
  logic               cmd_seq;
  logic               cmd_delay;
  logic               busy;
  logic [REACT_W-1:0] react_time;
  logic               react_valid;
  logic               jump_start;

  modport master (
    output trigger, react,
    input  data_out, cmd_seq, cmd_delay, busy, react_time, react_valid, jump_start
  );

  modport slave (
    input  trigger, react,
    output data_out, cmd_seq, cmd_delay, busy, react_time, react_valid, jump_start
  );
endinterface

// File: rtl/f1_start_ctrl.sv
// F1 start-light controller: steps the 8-light bar, holds for a pseudo-random
// number of ticks, then times the driver's reaction.
module f1_start_ctrl #(
  parameter int TICK_DIV  = 16,
  parameter int DELAY_MIN = 2,
  parameter int REACT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  f1_start_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DELAY_MIN + 128);

  typedef enum logic [1:0] {IDLE, SEQ, HOLD, GO} state_t;

  state_t             state;
  logic [TW-1:0]      tcnt;
  logic [DW-1:0]      dcnt;
  logic [REACT_W-1:0] rcnt;
  logic [6:0]         lfsr;
  logic [7:0]         lights;
  logic [REACT_W-1:0] react_time;
  logic               react_valid;
  logic               jump_start;
  logic               tick;

  assign tick = ((state == SEQ) || (state == HOLD)) && (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      lfsr        <= 7'h01;
      lights      <= '0;
      react_time  <= '0;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
    end else begin
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      react_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          lights <= '0;
          if (bus.trigger) begin
            state      <= SEQ;
            tcnt       <= '0;
            jump_start <= 1'b0;
          end
        end
        SEQ: begin
          if (bus.react) begin
            lights     <= '0;
            jump_start <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick) begin
              lights <= {lights[6:0], 1'b1};
              // bit 6 already lit means this step completes the bar
              if (lights[6]) begin
                state <= HOLD;
                tcnt  <= '0;
                dcnt  <= DW'(DELAY_MIN) + DW'(lfsr);
              end
            end
          end
        end
        HOLD: begin
          if (bus.react) begin
            lights     <= '0;
            jump_start <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick) begin
              if (dcnt == DW'(1)) begin
                lights <= '0;
                rcnt   <= '0;
                state  <= GO;
              end else begin
                dcnt <= dcnt - 1'b1;
              end
            end
          end
        end
        GO: begin
          if (bus.react) begin
            react_time  <= rcnt;
            react_valid <= 1'b1;
            state       <= IDLE;
          end else if (rcnt != '1) begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = lights;
  assign bus.cmd_seq     = (state == SEQ);
  assign bus.cmd_delay   = (state == HOLD);
  assign bus.busy        = (state != IDLE);
  assign bus.react_time  = react_time;
  assign bus.react_valid = react_valid;
  assign bus.jump_start  = jump_start;
endmodule

// File: doc/f1_start_ctrl.md
# f1_start_ctrl

Self-timed controller for the F1 start-light sequence: it sequences the 8-light bar from one `trigger`, holds all lights for a pseudo-random delay, then measures driver reaction time. It owns the light step prescaler, the random hold generator and the reaction timer. It drives the light bar directly and exports the same `cmd_seq`/`cmd_delay` phase strobes as the light FSM, so it can replace the free-running light FSM in the top level.

## Interface
- `TICK_DIV`, default 16: clock cycles per light step / delay tick; must be ≥ 2.
- `DELAY_MIN`, default 2: minimum hold in ticks; must be ≥ 1.
- `REACT_W`, default 16: width of the reaction timer.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in 1: start request, synchronous level; sampled only in IDLE.
- `react` in 1: driver button, synchronous level.
- `data_out` out 8: light bar, thermometer code.
- `cmd_seq` out 1: high while lights are being sequenced (SEQ).
- `cmd_delay` out 1: high during the random hold (HOLD).
- `busy` out 1: high when state ≠ IDLE.
- `react_time` out REACT_W: last measured reaction, in cycles; holds its value until the next capture.
- `react_valid` out 1: one-cycle pulse when `react_time` updates.
- `jump_start` out 1: sticky flag; cleared when the next trigger is accepted.

## Operation
- Reset values: state IDLE, `data_out`=0, `react_time`=0, `react_valid`=0, `jump_start`=0, tick counter 0, LFSR=7'h01.
- LFSR: 7-bit Fibonacci, x^7+x^6+1, advances every cycle in every state. Its value never reaches 0.
- Tick counter: cleared on entry to SEQ and HOLD; increments each cycle in SEQ/HOLD. `tick` is asserted when the count equals TICK_DIV-1, and the counter then wraps to 0.
- `cmd_seq`, `cmd_delay` and `busy` are Moore decodes of the state register.
- IDLE:
  - `data_out`=0.
  - If `trigger`=1: go to SEQ and clear `jump_start`.
  - `react` is ignored.
- SEQ:
  - On each tick: `data_out` <= {data_out[6:0],1'b1}.
  - On the tick that makes `data_out`=8'hFF: go to HOLD and load the delay counter with D = DELAY_MIN + LFSR value at that edge.
- HOLD:
  - `data_out`=8'hFF.
  - Delay counter decrements on each tick.
  - On a tick with delay counter = 1: `data_out` <= 0, clear the reaction counter, go to GO.
- GO:
  - Reaction counter increments each cycle and saturates at all-ones.
  - On `react`=1: `react_time` <= reaction counter, `react_valid` pulses, go to IDLE.
  - There is no timeout; a saturated counter waits indefinitely.
- Jump start: `react`=1 in SEQ or HOLD → `data_out` <= 0, `jump_start` <= 1, go to IDLE. `react_valid` is not pulsed and `react_time` is unchanged.
- Priority: `react` has priority over a simultaneous tick transition (a react on the final SEQ tick or final HOLD tick is a jump start).
- `trigger` while `busy` is ignored; it is not queued.
- An asserted `rst` mid-operation forces all reset values immediately. After release, the first sequence restarts only on a new `trigger`.

## Timing
- Trigger sampled at edge E0 → `busy`/`cmd_seq` high after E0.
- First light after E0 + TICK_DIV cycles; light n (n=1..8) after E0 + n·TICK_DIV.
- HOLD lasts D·TICK_DIV cycles; lights-out occurs at E0 + (8+D)·TICK_DIV.
- D range: DELAY_MIN+1 … DELAY_MIN+127 ticks.
- Reaction count: `react` sampled high on the k-th edge after lights-out (k=0 is the edge ending the first GO cycle) gives `react_time`=k.
- `react_valid` and the return to IDLE occur after that same edge.
- Back-to-back: `trigger` may be accepted on the first IDLE cycle after capture.

## Test plan
- Sequence timing (TICK_DIV=4): pulse `trigger`.
  - → `data_out` steps 01,03,…,FF every 4 cycles.
  - → `cmd_seq` high for exactly 32 cycles, then `cmd_delay` rises.
- Random hold: after reset, trigger at a known cycle.
  - → HOLD length = (2 + LFSR model value)·4 cycles, matching a reference LFSR model.
  - → Two consecutive runs give different D.
- Reaction: raise `react` 5 edges after lights-out.
  - → `react_time`=5, single-cycle `react_valid`, `busy` low.
- Jump start: assert `react` during SEQ at light 3.
  - → `data_out`=0 and `jump_start`=1 next cycle; `react_time` unchanged.
  - → Next `trigger` clears `jump_start`.
- Reset mid-HOLD: assert `rst` asynchronously between edges.
  - → `data_out`=0, `busy`=0, `cmd_delay`=0 immediately, without waiting for a clock edge.
  - → No activity until the next `trigger`.
- Busy trigger/saturation (REACT_W=4): pulse `trigger` during HOLD → ignored. Hold `react` low 20 cycles in GO, then press → `react_time`=15.
